// File: rtl/weight_load_sched.sv
// Weight-load sequencer: scatters a host weight tile row-major across the column
// buffers, then drains them with a one-step-per-column skew for the systolic array.
module weight_load_sched #(
    parameter int NUM_COLS = 4,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 tile_rows,
    input  logic                       host_valid,
    input  logic signed [15:0]         host_data,
    output logic                       host_ready,
    output logic [NUM_COLS-1:0]        buf_valid_data_out,
    output logic signed [15:0]         buf_data_out,
    input  logic                       drain_en,
    output logic [NUM_COLS-1:0]        buf_valid_in_out,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int CW = $clog2(NUM_COLS);
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [7:0]            row_q, row_d;
    logic [7:0]            rows_q, rows_d;
    logic [8:0]            step_q, step_d;
    logic [8:0]            last_step;
    logic [NUM_COLS-1:0]   col_onehot;
    logic [NUM_COLS-1:0]   drain_vec;
    logic [NUM_COLS-1:0]   vdata_d;
    logic [NUM_COLS-1:0]   vin_d;
    logic signed [15:0]    data_d;
    logic                  err_d;
    logic                  rows_ok;

    assign rows_ok    = (tile_rows != 8'd0) && (tile_rows <= 8'(DEPTH));
    assign last_step  = {1'b0, rows_q} + 9'(NUM_COLS - 2);
    assign col_onehot = NUM_COLS'(1) << col_q;
    assign host_ready = (state_q == LOAD);

    // Column c is dequeued on steps c .. c+rows-1, giving the diagonal wavefront.
    always_comb begin
        drain_vec = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            drain_vec[c] = (step_q >= 9'(c)) && (step_q < (9'(c) + {1'b0, rows_q}));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        rows_d  = rows_q;
        step_d  = step_q;
        vdata_d = '0;
        vin_d   = '0;
        data_d  = buf_data_out;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (rows_ok) begin
                        rows_d  = tile_rows;
                        col_d   = '0;
                        row_d   = 8'd0;
                        step_d  = 9'd0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (host_valid) begin
                    vdata_d = col_onehot;
                    data_d  = host_data;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == rows_q - 8'd1) state_d = DRAIN;
                        else                        row_d   = row_q + 8'd1;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                // The final step is left visible for one cycle before DONE, so done trails the last strobe.
                if (step_q > last_step) begin
                    state_d = DONE;
                end else if (drain_en) begin
                    vin_d  = drain_vec;
                    step_d = step_q + 9'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q              <= '0;
            row_q              <= 8'd0;
            rows_q             <= 8'd0;
            step_q             <= 9'd0;
            buf_valid_data_out <= '0;
            buf_data_out       <= '0;
            buf_valid_in_out   <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            col_q              <= col_d;
            row_q              <= row_d;
            rows_q             <= rows_d;
            step_q             <= step_d;
            buf_valid_data_out <= vdata_d;
            buf_data_out       <= data_d;
            buf_valid_in_out   <= vin_d;
            busy               <= (state_d != IDLE);
            done               <= (state_d == DONE);
            err                <= err_d;
        end
    end

endmodule

// File: tb/tb_weight_load_sched.sv
// Scoreboard bench for weight_load_sched: stimulus queues timed expectations,
// a negedge monitor pops and compares whenever the DUT raises a strobe or done.
module tb_weight_load_sched;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         tile_rows;
    logic               host_valid;
    logic signed [15:0] host_data;
    logic               host_ready;
    logic [3:0]         buf_valid_data_out;
    logic signed [15:0] buf_data_out;
    logic               drain_en;
    logic [3:0]         buf_valid_in_out;
    logic               busy;
    logic               done;
    logic               err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  vec;
        logic [15:0] data;
    } exp_t;

    exp_t load_q[$];
    exp_t drain_q[$];
    int   done_q[$];
    exp_t mon_e;
    int   mon_d;

    logic [3:0] col_vec[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] drain2[5]  = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
    logic [3:0] drain1[4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    weight_load_sched #(.NUM_COLS(4), .DEPTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .tile_rows          (tile_rows),
        .host_valid         (host_valid),
        .host_data          (host_data),
        .host_ready         (host_ready),
        .buf_valid_data_out (buf_valid_data_out),
        .buf_data_out       (buf_data_out),
        .drain_en           (drain_en),
        .buf_valid_in_out   (buf_valid_in_out),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every strobe or done must match the oldest queued expectation, on the expected cycle.
    always @(negedge clk) begin
        if (load_q.size() != 0 && load_q[0].cyc < cyc) begin
            mon_e = load_q.pop_front();
            checks++; failures++;
            $display("[TB] FAIL load_missing: got no strobe expected %0h at cycle %0d", mon_e.vec, mon_e.cyc);
        end
        if (buf_valid_data_out != 4'b0000) begin
            if (load_q.size() == 0) begin
                checks++; failures++;
                $display("[TB] FAIL load_unexpected: got %0h expected none (cycle %0d)", buf_valid_data_out, cyc);
            end else begin
                mon_e = load_q.pop_front();
                checkOutput("load_cycle", cyc, mon_e.cyc);
                checkOutput("load_strobe", {28'd0, buf_valid_data_out}, {28'd0, mon_e.vec});
                checkOutput("load_data", {16'd0, buf_data_out}, {16'd0, mon_e.data});
            end
        end
        if (drain_q.size() != 0 && drain_q[0].cyc < cyc) begin
            mon_e = drain_q.pop_front();
            checks++; failures++;
            $display("[TB] FAIL drain_missing: got no strobe expected %0h at cycle %0d", mon_e.vec, mon_e.cyc);
        end
        if (buf_valid_in_out != 4'b0000) begin
            if (drain_q.size() == 0) begin
                checks++; failures++;
                $display("[TB] FAIL drain_unexpected: got %0h expected none (cycle %0d)", buf_valid_in_out, cyc);
            end else begin
                mon_e = drain_q.pop_front();
                checkOutput("drain_cycle", cyc, mon_e.cyc);
                checkOutput("drain_strobe", {28'd0, buf_valid_in_out}, {28'd0, mon_e.vec});
            end
        end
        if (done_q.size() != 0 && done_q[0] < cyc) begin
            mon_d = done_q.pop_front();
            checks++; failures++;
            $display("[TB] FAIL done_missing: got no pulse expected at cycle %0d", mon_d);
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++; failures++;
                $display("[TB] FAIL done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_d = done_q.pop_front();
                checkOutput("done_cycle", cyc, mon_d);
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic [7:0] tr, input logic hv,
                                 input logic [15:0] hd, input logic de);
        start      = st;
        tile_rows  = tr;
        host_valid = hv;
        host_data  = hd;
        drain_en   = de;
        @(posedge clk);
        #1;
    endtask

    task automatic loadTile(input int rows, input logic [15:0] base, input logic [7:0] vpat,
                            input int plen, input int inject);
        int          acc;
        int          idx;
        logic        hv;
        logic        st;
        logic [15:0] d;
        acc = 0;
        idx = 0;
        applyStimulus(1'b1, 8'(rows), 1'b0, 16'h0, 1'b0);
        checkOutput("load_busy", busy, 1);
        checkOutput("load_no_err", err, 0);
        while (acc < rows * 4) begin
            hv = vpat[idx % plen];
            st = (idx == inject);
            d  = base + 16'(acc);
            checkOutput("host_ready_in_load", host_ready, 1);
            if (hv) begin
                load_q.push_back(exp_t'{cyc + 1, col_vec[acc % 4], d});
                acc++;
            end
            applyStimulus(st, 8'd2, hv, d, 1'b0);
            if (st) checkOutput("ignored_start_err", err, 0);
            idx++;
        end
        checkOutput("host_ready_after_last", host_ready, 0);
        checkOutput("busy_in_drain", busy, 1);
    endtask

    task automatic drainTile(input int rows, input logic [7:0] dpat, input int plen);
        int   k;
        int   idx;
        logic de;
        k   = 0;
        idx = 0;
        while (k < rows + 3) begin
            de = dpat[idx % plen];
            if (de) begin
                drain_q.push_back(exp_t'{cyc + 1, (rows == 2) ? drain2[k] : drain1[k], 16'h0});
                k++;
            end
            applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, de);
            idx++;
        end
        done_q.push_back(cyc + 1);
        checkOutput("done_not_with_strobe", done, 0);
        applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 1'b1);
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_in_done", busy, 1);
        applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 1'b0);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("host_ready_idle", host_ready, 0);
    endtask

    task automatic rejectStart(input logic [7:0] tr);
        applyStimulus(1'b1, tr, 1'b0, 16'h0, 1'b0);
        checkOutput("reject_err", err, 1);
        checkOutput("reject_busy", busy, 0);
        checkOutput("reject_ready", host_ready, 0);
        applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 1'b0);
        checkOutput("reject_err_one_cycle", err, 0);
        checkOutput("reject_still_idle", busy, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_host_ready"}, host_ready, 0);
        checkOutput({tag, "_load_strobe"}, {28'd0, buf_valid_data_out}, 0);
        checkOutput({tag, "_data"}, {16'd0, buf_data_out}, 0);
        checkOutput({tag, "_drain_strobe"}, {28'd0, buf_valid_in_out}, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        tile_rows  = 8'd0;
        host_valid = 1'b0;
        host_data  = 16'h0;
        drain_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 1'b0);

        // Tile of 2 rows, back-to-back beats, continuous drain.
        loadTile(2, 16'h0001, 8'hFF, 1, -1);
        drainTile(2, 8'hFF, 1);

        // Same tile, drain stalled by drain_en pattern 1,0,1,1,0,1,1.
        loadTile(2, 16'h0001, 8'hFF, 1, -1);
        drainTile(2, 8'b0110_1101, 7);

        // Gappy host_valid 1,0,0,1,1,0 with a start injected mid-load; negative data.
        loadTile(2, 16'h8001, 8'b0001_1001, 6, 1);
        drainTile(2, 8'hFF, 1);

        rejectStart(8'd0);
        rejectStart(8'd9);

        // Reset while the drain step counter sits at 2.
        loadTile(2, 16'h0100, 8'hFF, 1, -1);
        drain_q.push_back(exp_t'{cyc + 1, drain2[0], 16'h0});
        applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 1'b1);
        drain_q.push_back(exp_t'{cyc + 1, drain2[1], 16'h0});
        applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 1'b1);
        checkAllZero("mid_drain_reset");
        rst = 1'b0;
        applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 1'b0);
        checkOutput("post_reset_idle", busy, 0);

        loadTile(1, 16'hFFF0, 8'hFF, 1, -1);
        drainTile(1, 8'hFF, 1);

        repeat (3) applyStimulus(1'b0, 8'd0, 1'b0, 16'h0, 1'b0);
        checkOutput("load_queue_empty", load_q.size(), 0);
        checkOutput("drain_queue_empty", drain_q.size(), 0);
        checkOutput("done_queue_empty", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_load_sched.md
Name: weight_load_sched

Overview:
- Sequencer in front of a bank of NUM_COLS per-column weight accumulator buffers (one per systolic-array column).
- Accepts a tile of signed 16-bit weights from the host/unified-buffer stream and distributes them row-major across columns using per-column enqueue strobes.
- Once the tile is loaded, issues per-column dequeue strobes with a one-step skew per column, producing the diagonal wavefront the systolic array expects.

Parameters:
- NUM_COLS, 4, number of column buffers driven (2..16)
- DEPTH, 8, maximum rows per column buffer; legal tile_rows range is 1..DEPTH (DEPTH <= 255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a tile; sampled only in IDLE
- tile_rows  in  8  weights per column for this tile; latched on accepted start
- host_valid  in  1  host weight beat valid
- host_data  in  16 signed  host weight word
- host_ready  out  1  sequencer accepts a beat this cycle
- buf_valid_data_out  out  NUM_COLS  one-hot per-column enqueue strobe, registered
- buf_data_out  out  16 signed  weight word shared by all column buffers, registered
- drain_en  in  1  array can consume a drain step this cycle
- buf_valid_in_out  out  NUM_COLS  per-column dequeue strobes, registered
- busy  out  1  high in LOAD, DRAIN and DONE
- done  out  1  one-cycle pulse at tile completion
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: host_ready, strobes, buf_data_out, busy, done, err.
  - All counters (col, row, step) are cleared.
  - Reset in any state, including mid-LOAD or mid-DRAIN, discards the partial tile. The column buffers share rst, so they are cleared too.
- FSM states: IDLE -> LOAD -> DRAIN -> DONE -> IDLE.
- IDLE:
  - host_ready is 0.
  - If start=1 and 1 <= tile_rows <= DEPTH: latch rows <= tile_rows, clear counters, go to LOAD.
  - If start=1 and tile_rows is out of range: err=1 for the next cycle only, stay in IDLE.
- start while not in IDLE is ignored; no err pulse.
- LOAD:
  - host_ready = (state==LOAD), combinational from state.
  - Beat accepted when host_valid & host_ready.
  - On an accepted beat, next cycle: buf_data_out <= host_data and buf_valid_data_out <= one-hot(col). Latency is 1 cycle.
  - Cycles with no accepted beat: buf_valid_data_out=0 and buf_data_out holds its previous value.
  - Counter order: col increments 0..NUM_COLS-1, wraps to 0, and row increments on wrap.
  - The beat with row==rows-1 and col==NUM_COLS-1 is the last; after it the state moves to DRAIN.
  - host_ready is 0 from the cycle after the last beat. Total accepted beats = rows*NUM_COLS.
- DRAIN:
  - Step counter s runs 0..rows+NUM_COLS-2, width 9 bits.
  - In a cycle with drain_en=1, the next-cycle buf_valid_in_out[c] = 1 iff c <= s < c+rows; s then increments.
  - In a cycle with drain_en=0, the next-cycle buf_valid_in_out = 0 and s holds. The strobe pattern is only delayed, never altered.
  - After the step with s == rows+NUM_COLS-2 is issued, go to DONE.
  - Each column receives exactly rows dequeue strobes.
- DONE:
  - done=1 for one cycle, busy=1, then go to IDLE.
  - start is not accepted in DONE.
- busy = (state != IDLE), registered with the state.
- No arithmetic on data; host_data is passed through unmodified (signed 16-bit).

Test Plan:
- NUM_COLS=4, DEPTH=8. start with tile_rows=2, then 8 back-to-back beats 0x0001..0x0008 -> required:
  - buf_valid_data_out sequence 0001,0010,0100,1000,0001,0010,0100,1000, each with buf_data_out equal to the matching beat, 1 cycle after acceptance.
  - host_ready low from the cycle after beat 8.
- Continue with drain_en tied 1 -> required:
  - buf_valid_in_out over 5 consecutive cycles is 0001,0011,0110,1100,1000.
  - done pulses once on the cycle after the last strobe, then busy=0.
- Same tile with drain_en pattern 1,0,1,1,0,1,1 -> required: the same 5 strobe vectors, with all-zero cycles inserted after each drain_en=0 cycle; done only after the 5th vector.
- LOAD with host_valid pattern 1,0,0,1,1,0,... -> required: only valid beats produce strobes, column order is unbroken, and the state leaves LOAD exactly after the 8th accepted beat.
- Rejected and ignored starts:
  - start with tile_rows=0 -> err=1 for one cycle, stays IDLE, busy=0.
  - start with tile_rows=9 -> err=1 for one cycle, stays IDLE, busy=0.
  - start during LOAD -> no effect, no err.
- rst asserted at drain step s=2 -> required:
  - next cycle all outputs are 0 and the state is IDLE.
  - a subsequent start with tile_rows=1 and 4 beats completes normally: drain vectors 0001,0010,0100,1000.
